sg_sample_buffer: RTL and testbench

SG_SAMPLE_BUFFER -- requirements
Module: sg_sample_buffer

---
 rtl/sg_pkg.sv | 9 +
 rtl/sg_sample_buffer_if.sv | 30 +++
 rtl/sg_fifo_ram.sv | 24 ++
 rtl/sg_sample_buffer.sv | 108 ++++++++++
 tb/tb_sg_sample_buffer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/sg_pkg.sv
// Shared defaults and sample type for the SG sample buffer slice.
package sg_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 16;

    typedef logic [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/sg_sample_buffer_if.sv
// Upstream push, downstream pop and status signals of the SG sample buffer.
interface sg_sample_buffer_if
    import sg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);

    logic                    req;
    logic [DATA_W-1:0]       dat;
    logic                    rdy;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_ready;
    logic [$clog2(DEPTH):0]  level;
    logic [DATA_W-1:0]       peak;
    logic                    clr_peak;
    logic [31:0]             sample_cnt;

    modport master (
        output req, dat, out_ready, clr_peak,
        input  rdy, out_valid, out_data, level, peak, sample_cnt
    );

    modport slave (
        input  req, dat, out_ready, clr_peak,
        output rdy, out_valid, out_data, level, peak, sample_cnt
    );

endinterface

// File: rtl/sg_fifo_ram.sv
// Sample storage: dual-port, synchronous write, asynchronous read, no reset.
module sg_fifo_ram
    import sg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sg_sample_buffer.sv
// First-word-fall-through SG sample buffer with registered head, level,
// peak tracking and accepted-sample counter.
module sg_sample_buffer
    import sg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    sg_sample_buffer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_next;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_next;
    logic [1:0]        occ_q;
    logic [1:0]        occ_next;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] head_next;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] peak_q;
    logic [31:0]       cnt_q;
    logic              push;
    logic              pop;

    assign push = bus.req && (occ_q != OCC_FULL);
    assign pop  = bus.out_ready && (occ_q != OCC_EMPTY);

    sg_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.dat),
        .raddr (rd_next),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
        level_next = level_q;
        case ({push, pop})
            2'b10:   level_next = level_q + LW'(1);
            2'b01:   level_next = level_q - LW'(1);
            default: level_next = level_q;
        endcase

        if (level_next == '0)
            occ_next = OCC_EMPTY;
        else if (level_next == LW'(DEPTH))
            occ_next = OCC_FULL;
        else
            occ_next = OCC_PARTIAL;

        // The incoming sample becomes the head when nothing older remains after the pop.
        if (level_next == '0)
            head_next = '0;
        else if (push && ((level_q - LW'(pop)) == '0))
            head_next = bus.dat;
        else
            head_next = ram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            occ_q   <= OCC_EMPTY;
            head_q  <= '0;
            peak_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_next;
            level_q <= level_next;
            occ_q   <= occ_next;
            head_q  <= head_next;

            if (push) begin
                if (bus.clr_peak || (bus.dat > peak_q)) peak_q <= bus.dat;
                cnt_q <= cnt_q + 32'd1;
            end else if (bus.clr_peak) begin
                peak_q <= '0;
            end
        end
    end

    assign bus.rdy        = (occ_q != OCC_FULL);
    assign bus.out_valid  = (occ_q != OCC_EMPTY);
    assign bus.out_data   = head_q;
    assign bus.level      = level_q;
    assign bus.peak       = peak_q;
    assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_sg_sample_buffer.sv
// Directed self-checking bench for sg_sample_buffer.
module tb_sg_sample_buffer;
    import sg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    sg_sample_buffer_if #(.DATA_W(16), .DEPTH(16)) bus ();

    sg_sample_buffer #(.DATA_W(16), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_one(input sample_t d);
        bus.req = 1'b1;
        bus.dat = d;
        tick();
        bus.req = 1'b0;
    endtask

    initial begin
        sample_t v;
        bus.req       = 1'b0;
        bus.dat       = '0;
        bus.out_ready = 1'b0;
        bus.clr_peak  = 1'b0;

        // reset state
        #2;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_rdy", 32'(bus.rdy), 32'd1);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_peak", 32'(bus.peak), 32'd0);
        chk("rst_cnt", bus.sample_cnt, 32'd0);
        tick();
        rst = 1'b0;

        // single push, one-cycle latency
        bus.req = 1'b1;
        bus.dat = 16'h00A5;
        #1;
        chk("s_rdy_pre", 32'(bus.rdy), 32'd1);
        chk("s_valid_pre", 32'(bus.out_valid), 32'd0);
        tick();
        bus.req = 1'b0;
        chk("s_valid", 32'(bus.out_valid), 32'd1);
        chk("s_data", 32'(bus.out_data), 32'h00A5);
        chk("s_level", 32'(bus.level), 32'd1);
        chk("s_peak", 32'(bus.peak), 32'h00A5);
        chk("s_cnt", bus.sample_cnt, 32'd1);

        // fill to full, hold a 17th request, then drain in order
        do_reset();
        for (int i = 1; i <= 16; i++) push_one(16'(i));
        chk("f_level", 32'(bus.level), 32'd16);
        chk("f_rdy", 32'(bus.rdy), 32'd0);
        bus.req = 1'b1;
        bus.dat = 16'h0011;
        tick();
        tick();
        chk("f_hold_level", 32'(bus.level), 32'd16);
        chk("f_hold_cnt", bus.sample_cnt, 32'd16);
        chk("f_hold_data", 32'(bus.out_data), 32'h0001);
        chk("f_hold_peak", 32'(bus.peak), 32'h0010);
        chk("f_hold_rdy", 32'(bus.rdy), 32'd0);
        bus.req = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("d_valid", 32'(bus.out_valid), 32'd1);
            chk("d_data", 32'(bus.out_data), 32'(i));
            tick();
        end
        chk("d_level", 32'(bus.level), 32'd0);
        chk("d_valid_end", 32'(bus.out_valid), 32'd0);
        chk("d_rdy_end", 32'(bus.rdy), 32'd1);
        tick();
        chk("e_level", 32'(bus.level), 32'd0);
        bus.out_ready = 1'b0;

        // steady push+pop at level 8
        do_reset();
        for (int i = 0; i < 8; i++) push_one(16'h0100 + 16'(i));
        chk("pp_level0", 32'(bus.level), 32'd8);
        bus.out_ready = 1'b1;
        bus.req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.dat = 16'h0200 + 16'(k);
            v = (k < 8) ? 16'h0100 + 16'(k) : 16'h0200 + 16'(k - 8);
            chk("pp_data", 32'(bus.out_data), 32'(v));
            tick();
            chk("pp_level", 32'(bus.level), 32'd8);
        end
        bus.req = 1'b0;
        bus.out_ready = 1'b0;
        chk("pp_cnt", bus.sample_cnt, 32'd28);
        chk("pp_next", 32'(bus.out_data), 32'h020C);

        // peak tracking and clear
        do_reset();
        push_one(16'h0300);
        push_one(16'h7FFF);
        push_one(16'h0010);
        chk("pk_max", 32'(bus.peak), 32'h7FFF);
        bus.clr_peak = 1'b1;
        push_one(16'h0042);
        chk("pk_clr_push", 32'(bus.peak), 32'h0042);
        tick();
        bus.clr_peak = 1'b0;
        chk("pk_clr", 32'(bus.peak), 32'h0000);
        push_one(16'h0005);
        chk("pk_after", 32'(bus.peak), 32'h0005);

        // reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) push_one(16'h0A00 + 16'(i));
        chk("mr_level5", 32'(bus.level), 32'd5);
        rst = 1'b1;
        #1;
        chk("mr_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_level", 32'(bus.level), 32'd0);
        chk("mr_rdy", 32'(bus.rdy), 32'd1);
        chk("mr_cnt", bus.sample_cnt, 32'd0);
        #2;
        rst = 1'b0;
        push_one(16'hBEEF);
        chk("mr_first_level", 32'(bus.level), 32'd1);
        chk("mr_first_data", 32'(bus.out_data), 32'hBEEF);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("mr_alone", 32'(bus.out_valid), 32'd0);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        chk("w_pre", bus.sample_cnt, 32'hFFFF_FFFF);
        push_one(16'h0001);
        chk("w_wrap", bus.sample_cnt, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
